latch_q_sync_monitor: RTL



---
 rtl/latch_q_sync_monitor_if.sv | 28 ++
 rtl/latch_q_sync_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/latch_q_sync_monitor_if.sv
`default_nettype none
// ============================================================================
// latch_q_sync_monitor_if : valid/ready event channel (rise flag + timestamp)
// Rev 1.0
// ============================================================================
interface latch_q_sync_monitor_if #(
   parameter int TS_W = 16
);
   logic            evt_valid;
   logic            evt_ready;
   logic            evt_rise;
   logic [TS_W-1:0] evt_ts;

   modport master (
      output evt_valid,
      output evt_rise,
      output evt_ts,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_rise,
      input  evt_ts,
      output evt_ready
   );
endinterface
`default_nettype wire

// File: rtl/latch_q_sync_monitor.sv
`default_nettype none
// ============================================================================
// latch_q_sync_monitor : syncs + debounces latch Q, queues filtered edge events
// Rev 1.0 | optional timestamping: define LATCH_MON_TIMESTAMP_EN
// ============================================================================
module latch_q_sync_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3,
   parameter int FIFO_DEPTH  = 4,
   parameter int TS_W        = 16,
   parameter int CNT_W       = 8
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              q_in,
   input  wire logic              clr,
   latch_q_sync_monitor_if.master evt,
   output logic                   q_stable,
   output logic [CNT_W-1:0]       rise_cnt,
   output logic [CNT_W-1:0]       fall_cnt,
   output logic                   overflow
);
   localparam int               PTR_W     = $clog2(FIFO_DEPTH);
   localparam int               FC_W      = 4;
   localparam logic [FC_W-1:0]  FILT_LAST = FC_W'(FILT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      STABLE = 1'b0,
      CAND   = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   q_sync;
   state_t                 state;
   logic [FC_W-1:0]        filt_cnt;
   logic                   commit;

   logic                   rise_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         count;
   logic                   full;
   logic                   pop;
   logic                   push;

   // ------------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], q_in};
      end
   end

   assign q_sync = sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce filter
   // ------------------------------------------------------------------
   // Commit is decided combinationally so the FIFO push and q_stable flip share one edge.
   always_comb begin
      commit = 1'b0;
      if (q_sync != q_stable) begin
         if (state == STABLE) begin
            commit = (FILT_CYCLES == 1);
         end else begin
            commit = ((filt_cnt + FC_W'(1)) == FILT_LAST);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= STABLE;
         filt_cnt <= '0;
         q_stable <= 1'b0;
      end else if (commit) begin
         q_stable <= ~q_stable;
         state    <= STABLE;
         filt_cnt <= '0;
      end else if (q_sync == q_stable) begin
         state    <= STABLE;
         filt_cnt <= '0;
      end else if (state == STABLE) begin
         state    <= CAND;
         filt_cnt <= FC_W'(1);
      end else begin
         filt_cnt <= filt_cnt + FC_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO (show-ahead)
   // ------------------------------------------------------------------
   assign full          = (count == FIFO_FULL);
   assign evt.evt_valid = (count != '0);
   assign pop           = evt.evt_valid && evt.evt_ready;
   // A pop in the same cycle frees a slot, so a commit on a full FIFO still lands.
   assign push          = commit && (!full || pop);
   assign evt.evt_rise  = rise_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         rise_mem[wr_ptr] <= ~q_stable;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Saturating edge counters and sticky overflow
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_cnt <= '0;
         fall_cnt <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         rise_cnt <= '0;
         fall_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (commit && !q_stable && (rise_cnt != CNT_MAX)) begin
            rise_cnt <= rise_cnt + CNT_W'(1);
         end
         if (commit && q_stable && (fall_cnt != CNT_MAX)) begin
            fall_cnt <= fall_cnt + CNT_W'(1);
         end
         if (commit && !push) begin
            overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Timestamp
   // ------------------------------------------------------------------
`ifdef LATCH_MON_TIMESTAMP_EN
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] ts_mem [FIFO_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts <= '0;
      end else if (clr) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ts_mem[wr_ptr] <= ts;
      end
   end

   assign evt.evt_ts = ts_mem[rd_ptr];
`else
   assign evt.evt_ts = '0;
`endif

endmodule
`default_nettype wire
